dma_stream_fifo: RTL and testbench

Parametrised valid/ready stream FIFO for the DMA datapath, replacing the fixed 512x256 SRAM FIFO wrapper between the read engine and the write engine. Adds first-word-fall-through output with a 1-cycle empty bypass, an occupancy count, programmable almost-full/almost-empty thresholds and a high-water mark for buffer tuning. Storage sits in a swappable dual-port RAM sub-module, so the same control logic serves register-file and SRAM-macro builds.

---
 rtl/dma_pkg.sv | 21 ++
 rtl/dma_fifo_ram.sv | 31 +++
 rtl/dma_stream_fifo.sv | 143 ++++++++++++++
 tb/tb_dma_stream_fifo.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared DMA datapath constants and helpers for the stream FIFO.
// The beat width and the FIFO depth remain macros so that builds can override them.
`ifndef DMA_DATA_WIDTH
`define DMA_DATA_WIDTH 256
`endif
`ifndef DMA_FIFO_DEPTH
`define DMA_FIFO_DEPTH 512
`endif

package dma_pkg;

  // AF default is a margin below DEPTH; AE default is an absolute level.
  localparam int DMA_FIFO_AF_DEFAULT = 4;
  localparam int DMA_FIFO_AE_DEFAULT = 4;

  // Width needed to hold a level in the range 0..depth.
  function automatic int dma_fifo_lvl_t(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dma_fifo_ram.sv
// Simple dual-port storage with a registered read port. The default body is a behavioural array;
// SRAM-macro builds swap this file for a wrapper that has the same ports.
module dma_fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dma_stream_fifo.sv
// Valid/ready stream FIFO with a first-word-fall-through head and an empty bypass.
// It also provides an occupancy level, almost-full/almost-empty flags and a high-water mark.
`ifndef DMA_DATA_WIDTH
`define DMA_DATA_WIDTH 256
`endif
`ifndef DMA_FIFO_DEPTH
`define DMA_FIFO_DEPTH 512
`endif

module dma_stream_fifo
  import dma_pkg::*;
#(
  parameter int WIDTH     = `DMA_DATA_WIDTH,
  parameter int DEPTH     = `DMA_FIFO_DEPTH,
  parameter int AF_THRESH = DEPTH - DMA_FIFO_AF_DEFAULT,
  parameter int AE_THRESH = DMA_FIFO_AE_DEFAULT,
  localparam int LW       = dma_fifo_lvl_t(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [LW-1:0]    level_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic [LW-1:0]    max_level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
  localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);

  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("dma_stream_fifo: WIDTH must be at least 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("dma_stream_fifo: DEPTH must be a power of 2 and at least 2");
    end
    if (AF_THRESH > DEPTH) begin : g_bad_af
      $error("dma_stream_fifo: AF_THRESH exceeds DEPTH");
    end
    if (AE_THRESH >= DEPTH) begin : g_bad_ae
      $error("dma_stream_fifo: AE_THRESH must be below DEPTH");
    end
  endgenerate

  logic [AW-1:0]    r_wptr, r_rptr;
  logic [LW-1:0]    r_ram_cnt, r_level, r_max_level;
  logic             r_head_valid, r_head_from_ram, r_in_ready;
  logic [WIDTH-1:0] r_head_data;
  logic [WIDTH-1:0] w_ram_rdata;

  logic             w_in_fire, w_out_fire, w_head_free;
  logic             w_prefetch, w_bypass, w_ram_we;
  logic [LW-1:0]    w_level_next;

  // The head is free when it is empty or is being consumed this cycle. A RAM read always wins over
  // the bypass, so a new beat can skip the RAM only when the RAM holds nothing older.
  always_comb begin
    w_in_fire    = in_valid_i & r_in_ready;
    w_out_fire   = r_head_valid & out_ready_i;
    w_head_free  = ~r_head_valid | w_out_fire;
    w_prefetch   = w_head_free & (r_ram_cnt != '0);
    w_bypass     = w_in_fire & w_head_free & (r_ram_cnt == '0);
    w_ram_we     = w_in_fire & ~w_bypass & ~clear_i;
    w_level_next = r_level + LW'(w_in_fire) - LW'(w_out_fire);
  end

  dma_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (r_wptr),
    .i_wdata (in_data_i),
    .i_re    (w_prefetch),
    .i_raddr (r_rptr),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr          <= '0;
      r_rptr          <= '0;
      r_ram_cnt       <= '0;
      r_level         <= '0;
      r_max_level     <= '0;
      r_head_valid    <= 1'b0;
      r_head_from_ram <= 1'b0;
      r_head_data     <= '0;
      r_in_ready      <= 1'b0;
    end else if (clear_i) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_ram_cnt    <= '0;
      r_level      <= '0;
      r_max_level  <= '0;
      r_head_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      if (w_ram_we) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_prefetch) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_ram_cnt <= r_ram_cnt + LW'(w_ram_we) - LW'(w_prefetch);

      // A prefetched head is served straight from the RAM read register, so there is no bubble.
      if (w_prefetch) begin
        r_head_valid    <= 1'b1;
        r_head_from_ram <= 1'b1;
      end else if (w_bypass) begin
        r_head_valid    <= 1'b1;
        r_head_from_ram <= 1'b0;
        r_head_data     <= in_data_i;
      end else if (w_out_fire) begin
        r_head_valid <= 1'b0;
      end

      r_level     <= w_level_next;
      r_in_ready  <= (w_level_next < DEPTH_L);
      r_max_level <= (w_level_next > r_max_level) ? w_level_next : r_max_level;
    end
  end

  assign in_ready_o     = r_in_ready;
  assign out_valid_o    = r_head_valid;
  assign out_data_o     = r_head_from_ram ? w_ram_rdata : r_head_data;
  assign level_o        = r_level;
  assign max_level_o    = r_max_level;
  assign almost_full_o  = (r_level >= AF_L);
  assign almost_empty_o = (r_level <= AE_L);

endmodule

// File: tb/tb_dma_stream_fifo.sv
// Directed and scoreboarded checks of dma_stream_fifo at DEPTH=8, WIDTH=16.
module tb_dma_stream_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int LW    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clear_i = 1'b0;
  logic             in_valid_i = 1'b0;
  logic             out_ready_i = 1'b0;
  logic [WIDTH-1:0] in_data_i = '0;
  logic             in_ready_o, out_valid_o, almost_full_o, almost_empty_o;
  logic [WIDTH-1:0] out_data_o;
  logic [LW-1:0]    level_o, max_level_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dma_stream_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .clear_i        (clear_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .in_data_i      (in_data_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_data_o     (out_data_o),
    .level_o        (level_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o),
    .max_level_o    (max_level_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] exp_d;
    bit exp_ready, in_fire, out_fire;
    int exp_max, lvl;

    // Reset values while rst is held.
    #2;
    check("rst_in_ready", 32'(in_ready_o), 32'd0);
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_out_data", 32'(out_data_o), 32'd0);
    check("rst_level", 32'(level_o), 32'd0);
    check("rst_max", 32'(max_level_o), 32'd0);
    check("rst_af", 32'(almost_full_o), 32'd0);
    check("rst_ae", 32'(almost_empty_o), 32'd1);
    step();
    step();
    rst = 1'b0;
    check("rel_in_ready_low", 32'(in_ready_o), 32'd0);
    step();
    check("rel_in_ready_high", 32'(in_ready_o), 32'd1);

    // Bypass into an empty FIFO.
    in_valid_i = 1'b1;
    in_data_i  = 16'h00A5;
    step();
    in_valid_i = 1'b0;
    check("byp_valid", 32'(out_valid_o), 32'd1);
    check("byp_data", 32'(out_data_o), 32'h00A5);
    check("byp_level", 32'(level_o), 32'd1);
    check("byp_ae", 32'(almost_empty_o), 32'd1);
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    check("byp_pop_valid", 32'(out_valid_o), 32'd0);
    check("byp_pop_level", 32'(level_o), 32'd0);
    check("byp_hold_data", 32'(out_data_o), 32'h00A5);
    $display("txn bypass 0xA5 done");

    // Fill with 10 offered beats; only 8 fit.
    for (int i = 0; i < 10; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = 16'(16'h0100 + i);
      check("fill_ready", 32'(in_ready_o), (i < DEPTH) ? 32'd1 : 32'd0);
      step();
      lvl = (i + 1 < DEPTH) ? i + 1 : DEPTH;
      check("fill_level", 32'(level_o), 32'(lvl));
      check("fill_af", 32'(almost_full_o), (lvl >= 4) ? 32'd1 : 32'd0);
    end
    in_valid_i = 1'b0;
    check("full_ready", 32'(in_ready_o), 32'd0);
    check("full_level", 32'(level_o), 32'd8);
    check("full_max", 32'(max_level_o), 32'd8);
    check("full_ae", 32'(almost_empty_o), 32'd0);
    check("full_head", 32'(out_data_o), 32'h0100);
    $display("txn fill to %0d beats done", DEPTH);

    // Full with a one-cycle pop while the producer keeps pushing.
    in_valid_i  = 1'b1;
    in_data_i   = 16'h0200;
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    check("fr_ready_open", 32'(in_ready_o), 32'd1);
    check("fr_level7", 32'(level_o), 32'd7);
    check("fr_head", 32'(out_data_o), 32'h0101);
    step();
    in_valid_i = 1'b0;
    check("fr_ready_shut", 32'(in_ready_o), 32'd0);
    check("fr_level8", 32'(level_o), 32'd8);
    check("fr_max", 32'(max_level_o), 32'd8);
    out_ready_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      exp_d = (i < DEPTH - 1) ? 16'(16'h0101 + i) : 16'h0200;
      check("fr_drain_valid", 32'(out_valid_o), 32'd1);
      check("fr_drain_data", 32'(out_data_o), 32'(exp_d));
      step();
    end
    out_ready_i = 1'b0;
    check("fr_empty_valid", 32'(out_valid_o), 32'd0);
    check("fr_empty_level", 32'(level_o), 32'd0);
    $display("txn full+read drain done");

    // Pointer wrap: three fill/drain rounds through the RAM.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        in_valid_i = 1'b1;
        in_data_i  = 16'(16'h0400 + r * 16 + i);
        step();
      end
      in_valid_i = 1'b0;
      check("wrap_level", 32'(level_o), 32'd8);
      out_ready_i = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        check("wrap_data", 32'(out_data_o), 32'(16'h0400 + r * 16 + i));
        step();
      end
      out_ready_i = 1'b0;
      check("wrap_empty", 32'(level_o), 32'd0);
      $display("txn wrap round %0d done", r);
    end

    // Streaming at one beat per cycle.
    in_valid_i  = 1'b1;
    out_ready_i = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      in_data_i = 16'(k);
      step();
      check("stream_valid", 32'(out_valid_o), 32'd1);
      check("stream_data", 32'(out_data_o), 32'(k));
      check("stream_level", 32'(level_o), 32'd1);
    end
    in_valid_i = 1'b0;
    step();
    out_ready_i = 1'b0;
    check("stream_end_valid", 32'(out_valid_o), 32'd0);
    check("stream_end_level", 32'(level_o), 32'd0);
    $display("txn stream 1000 beats done");

    // Clear with level 5 and a beat offered on the clear cycle.
    for (int i = 0; i < 5; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = 16'(16'h0300 + i);
      step();
    end
    check("clr_pre_level", 32'(level_o), 32'd5);
    clear_i   = 1'b1;
    in_data_i = 16'hDEAD;
    step();
    clear_i    = 1'b0;
    in_valid_i = 1'b0;
    check("clr_level", 32'(level_o), 32'd0);
    check("clr_valid", 32'(out_valid_o), 32'd0);
    check("clr_max", 32'(max_level_o), 32'd0);
    check("clr_ready", 32'(in_ready_o), 32'd1);
    in_valid_i = 1'b1;
    in_data_i  = 16'h0BEE;
    step();
    in_valid_i = 1'b0;
    check("clr_next_data", 32'(out_data_o), 32'h0BEE);
    check("clr_next_level", 32'(level_o), 32'd1);
    check("clr_next_max", 32'(max_level_o), 32'd1);
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    check("clr_final_valid", 32'(out_valid_o), 32'd0);
    $display("txn clear done");

    // Random traffic against a queue model, with rst asserted mid-burst.
    clear_i = 1'b1;
    step();
    clear_i   = 1'b0;
    exp_ready = 1'b1;
    exp_max   = 0;
    q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc == 200) begin
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid_o), 32'd0);
        check("arst_level", 32'(level_o), 32'd0);
        check("arst_ready", 32'(in_ready_o), 32'd0);
        check("arst_max", 32'(max_level_o), 32'd0);
        check("arst_data", 32'(out_data_o), 32'd0);
        step();
        rst = 1'b0;
        q.delete();
        exp_max   = 0;
        exp_ready = 1'b0;
        $display("txn async reset mid-burst done");
      end else begin
        in_valid_i  = 1'($urandom_range(0, 1));
        out_ready_i = ($urandom_range(0, 9) < 3);
        in_data_i   = 16'($urandom_range(0, 65535));
        check("rnd_ready", 32'(in_ready_o), 32'(exp_ready));
        check("rnd_valid", 32'(out_valid_o), (q.size() != 0) ? 32'd1 : 32'd0);
        check("rnd_level", 32'(level_o), 32'(q.size()));
        check("rnd_max", 32'(max_level_o), 32'(exp_max));
        if (q.size() != 0) begin
          check("rnd_data", 32'(out_data_o), 32'(q[0]));
        end
        in_fire  = in_valid_i && exp_ready;
        out_fire = out_ready_i && (q.size() != 0);
        if (out_fire) begin
          void'(q.pop_front());
        end
        if (in_fire) begin
          q.push_back(in_data_i);
        end
        exp_ready = (q.size() < DEPTH);
        if (q.size() > exp_max) begin
          exp_max = q.size();
        end
        step();
      end
    end
    $display("txn random traffic done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
